// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the architectural PC and issues sequential
// word fetches to instruction memory. Returned words are buffered with their
// PCs in a small FIFO and presented to decode. A redirect from the
// branch/jump decision stage moves the PC to the target, throws away
// wrong-path instructions and drains responses that are still in flight.
//
// Parameters:
//   RESET_PC : PC loaded on reset.
//   DEPTH    : FIFO entries; also the cap on outstanding + buffered.
//              Power of two, at least 2.
//
// Ports:
//   clk, rst         : clock (rising edge); asynchronous active-high reset.
//   o_imem_req       : fetch request valid.
//   o_imem_addr      : word-aligned fetch byte address.
//   i_imem_gnt       : memory takes the request this cycle.
//   i_imem_rvalid    : read data valid (in order, >=1 cycle after grant).
//   i_imem_rdata     : instruction word.
//   i_branch_flush   : redirect strobe.
//   i_branch_pc      : redirect target (bits [1:0] ignored).
//   o_if_valid       : instruction available to decode.
//   i_id_ready       : decode accepts the instruction.
//   o_if_pc          : PC of the presented instruction.
//   o_if_instr       : presented instruction.
//   o_dbg_state      : FSM state (0 = BOOT, 1 = RUN, 2 = DRAIN).
//
// Handshakes:
//   Memory side: a request transfers on a cycle where o_imem_req and
//   i_imem_gnt are both high; o_imem_addr is held while a request waits.
//   Decode side: an instruction transfers on a cycle where o_if_valid and
//   i_id_ready are both high; o_if_pc/o_if_instr are stable while valid
//   waits for ready (unless a redirect clears the buffer).
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_branch_flush,
  input  logic [31:0] i_branch_pc,
  output logic        o_if_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic [1:0]  o_dbg_state
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hold_pc_q, hold_instr_q;

  logic          req, grant, rsp, flush;
  logic          push, pop, clear;
  logic [CW:0]   occupancy;
  logic [31:0]   target;

  // Credit covers both words in flight and words already buffered, so a
  // response always finds a free FIFO slot.
  assign occupancy = {1'b0, out_q} + {1'b0, cnt_q};
  assign req       = (state_q == ST_RUN) && (occupancy < (CW+1)'(DEPTH));
  assign grant     = req && i_imem_gnt;
  // A response with nothing outstanding belongs to a request that reset
  // has forgotten about.
  assign rsp       = i_imem_rvalid && (out_q != '0);
  assign flush     = i_branch_flush && (state_q != ST_BOOT);
  assign target    = {i_branch_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;

    if (grant && !rsp) begin
      out_d = out_q + CW'(1);
    end else if (!grant && rsp) begin
      out_d = out_q - CW'(1);
    end

    pop = (cnt_q != '0) && i_id_ready;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (grant) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp) begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      ST_DRAIN: begin
        // Every outstanding response here is wrong-path: it only retires
        // credit. resp_pc already points at the redirect target.
        if (out_d == '0) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect overrides everything else this cycle. A grant taken in the
    // same cycle is already in out_d and will be drained like the rest.
    if (flush) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      push       = 1'b0;
      pop        = 1'b0;
      clear      = 1'b1;
      state_d    = (out_d == '0) ? ST_RUN : ST_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= NOP;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP;
    end else begin
      // Track whatever is on the outputs so they stay put once empty.
      if (cnt_q != '0) begin
        hold_pc_q    <= pc_mem_q[rd_ptr_q];
        hold_instr_q <= instr_mem_q[rd_ptr_q];
      end
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]    <= resp_pc_q;
          instr_mem_q[wr_ptr_q] <= i_imem_rdata;
          wr_ptr_q              <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
          cnt_q <= cnt_q + CW'(1);
        end else if (pop && !push) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = fetch_pc_q;
  assign o_if_valid  = (cnt_q != '0);
  assign o_if_pc     = o_if_valid ? pc_mem_q[rd_ptr_q]    : hold_pc_q;
  assign o_if_instr  = o_if_valid ? instr_mem_q[rd_ptr_q] : hold_instr_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  // Memory model returns address + DATA_OFS as the instruction word.
  localparam logic [31:0] DATA_OFS = 32'h1000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt     = 1'b0;
  logic        i_imem_rvalid  = 1'b0;
  logic [31:0] i_imem_rdata   = '0;
  logic        i_branch_flush = 1'b0;
  logic [31:0] i_branch_pc    = '0;
  logic        o_if_valid;
  logic        i_id_ready     = 1'b0;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic [1:0]  o_dbg_state;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .i_branch_flush (i_branch_flush),
    .i_branch_pc    (i_branch_pc),
    .o_if_valid     (o_if_valid),
    .i_id_ready     (i_id_ready),
    .o_if_pc        (o_if_pc),
    .o_if_instr     (o_if_instr),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- bench state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lat     = 1;
  logic        flush_v = 1'b0;
  logic [31:0] bpc_v   = '0;
  logic        ready_v = 1'b1;
  logic        gnt_v   = 1'b1;

  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [31:0] exp_q[$];      // expected PCs delivered to decode
  logic [31:0] exp_req_q[$];  // expected granted fetch addresses

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs on the falling edge, run the memory model,
  // and score requests and deliveries before the next rising edge.
  task automatic tick();
    logic [31:0] e;
    int          d;
    @(negedge clk);
    cyc++;
    i_branch_flush = flush_v;
    i_branch_pc    = bpc_v;
    i_id_ready     = ready_v;
    i_imem_gnt     = gnt_v;
    if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = pend_addr_q.pop_front() + DATA_OFS;
      d             = pend_due_q.pop_front();
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
    end
    #1;
    if (o_imem_req && i_imem_gnt) begin
      pend_addr_q.push_back(o_imem_addr);
      pend_due_q.push_back(cyc + lat);
      if (exp_req_q.size() > 0) begin
        e = exp_req_q.pop_front();
        check("req_addr", o_imem_addr, e);
      end
    end
    if (o_if_valid && i_id_ready && !i_branch_flush && !rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dlv_pc", o_if_pc, e);
        check("dlv_instr", o_if_instr, e + DATA_OFS);
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    flush_v = 1'b0;
    bpc_v   = '0;
    ready_v = 1'b1;
    gnt_v   = 1'b1;
    lat     = 1;
    pend_addr_q.delete();
    pend_due_q.delete();
    exp_q.delete();
    exp_req_q.delete();
    tick();
    tick();
  endtask

  task automatic finish_test(input string name);
    check({name, "_req_left"}, 32'(exp_req_q.size()), 32'd0);
    check({name, "_dlv_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    // 1: reset values, then straight-line fetch with 1-cycle memory.
    do_reset();
    check("rst_req",   32'(o_imem_req),  32'd0);
    check("rst_addr",  o_imem_addr,      RESET_PC);
    check("rst_valid", 32'(o_if_valid),  32'd0);
    check("rst_pc",    o_if_pc,          32'd0);
    check("rst_instr", o_if_instr,       NOP);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    exp_q     = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    rst = 1'b0;
    tick();
    check("t1_state_run", 32'(o_dbg_state), 32'd1);
    check("t1_valid_a",   32'(o_if_valid),  32'd0);
    tick();
    check("t1_valid_b",   32'(o_if_valid),  32'd0);
    repeat (18) tick();
    finish_test("t1");

    // 2: decode stalls, FIFO fills, requests stop without skipping.
    do_reset();
    ready_v   = 1'b0;
    exp_req_q = '{32'h0, 32'h4};
    rst = 1'b0;
    repeat (10) tick();
    check("t2_req_stop",  32'(o_imem_req), 32'd0);
    check("t2_addr_held", o_imem_addr,     32'h8);
    check("t2_valid",     32'(o_if_valid), 32'd1);
    check("t2_head_pc",   o_if_pc,         32'h0);
    check("t2_head_ins",  o_if_instr,      DATA_OFS);
    check("t2_reqs_done", 32'(exp_req_q.size()), 32'd0);
    ready_v   = 1'b1;
    exp_req_q = '{32'h8, 32'hC, 32'h10};
    exp_q     = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    repeat (15) tick();
    finish_test("t2");

    // 3: flush with two late responses in flight.
    do_reset();
    lat       = 3;
    exp_req_q = '{32'h0, 32'h4, 32'h100, 32'h104};
    exp_q     = '{32'h100, 32'h104};
    rst = 1'b0;
    tick();
    tick();
    flush_v = 1'b1;
    bpc_v   = 32'h100;
    tick();
    flush_v = 1'b0;
    check("t3_no_req_full", 32'(o_imem_req), 32'd0);
    tick();
    check("t3_drain_a",     32'(o_dbg_state), 32'd2);
    check("t3_drain_noreq", 32'(o_imem_req),  32'd0);
    tick();
    check("t3_drain_b",     32'(o_dbg_state), 32'd2);
    tick();
    check("t3_run",         32'(o_dbg_state), 32'd1);
    check("t3_target_req",  32'(o_imem_req),  32'd1);
    check("t3_target_addr", o_imem_addr,      32'h100);
    repeat (15) tick();
    finish_test("t3");

    // 4a: flush to a misaligned target with nothing outstanding.
    do_reset();
    ready_v = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    check("t4_fill_req",   32'(o_imem_req), 32'd0);
    check("t4_fill_valid", 32'(o_if_valid), 32'd1);
    flush_v = 1'b1;
    bpc_v   = 32'h203;
    tick();
    flush_v   = 1'b0;
    exp_req_q = '{32'h200, 32'h204};
    exp_q     = '{32'h200, 32'h204, 32'h208};
    ready_v   = 1'b1;
    tick();
    check("t4_addr",       o_imem_addr,     32'h200);
    check("t4_req",        32'(o_imem_req), 32'd1);
    check("t4_cleared",    32'(o_if_valid), 32'd0);
    check("t4_hold_pc",    o_if_pc,         32'h0);
    check("t4_hold_instr", o_if_instr,      DATA_OFS);
    repeat (15) tick();
    finish_test("t4a");

    // 4b: flush in the same cycle as a response and a pop.
    do_reset();
    exp_req_q = '{32'h0, 32'h4, 32'h300, 32'h304};
    exp_q     = '{32'h300, 32'h304};
    rst = 1'b0;
    tick();
    tick();
    flush_v = 1'b1;
    bpc_v   = 32'h300;
    tick();
    flush_v = 1'b0;
    check("t4b_pop_valid", 32'(o_if_valid), 32'd1);
    check("t4b_head_pc",   o_if_pc,         32'h0);
    tick();
    check("t4b_cleared",   32'(o_if_valid),  32'd0);
    check("t4b_addr",      o_imem_addr,      32'h300);
    check("t4b_state",     32'(o_dbg_state), 32'd1);
    repeat (15) tick();
    finish_test("t4b");

    // 5: second redirect while draining from the first.
    do_reset();
    lat       = 4;
    exp_req_q = '{32'h0, 32'h4, 32'h400, 32'h404};
    exp_q     = '{32'h400, 32'h404};
    rst = 1'b0;
    tick();
    tick();
    flush_v = 1'b1;
    bpc_v   = 32'h100;
    tick();
    bpc_v   = 32'h400;
    tick();
    flush_v = 1'b0;
    check("t5_drain_a",  32'(o_dbg_state), 32'd2);
    check("t5_first_tg", o_imem_addr,      32'h100);
    tick();
    check("t5_drain_b",  32'(o_dbg_state), 32'd2);
    check("t5_retarget", o_imem_addr,      32'h400);
    tick();
    check("t5_drain_c",  32'(o_dbg_state), 32'd2);
    tick();
    check("t5_run",      32'(o_dbg_state), 32'd1);
    check("t5_req",      32'(o_imem_req),  32'd1);
    check("t5_addr",     o_imem_addr,      32'h400);
    repeat (20) tick();
    finish_test("t5");

    // 6: asynchronous reset in the middle of a drain.
    do_reset();
    lat = 4;
    rst = 1'b0;
    tick();
    tick();
    flush_v = 1'b1;
    bpc_v   = 32'h100;
    tick();
    flush_v = 1'b0;
    tick();
    check("t6_drain", 32'(o_dbg_state), 32'd2);
    check("t6_addr",  o_imem_addr,      32'h100);
    rst = 1'b1;
    #1;
    check("t6_async_req",   32'(o_imem_req),  32'd0);
    check("t6_async_addr",  o_imem_addr,      RESET_PC);
    check("t6_async_valid", 32'(o_if_valid),  32'd0);
    check("t6_async_pc",    o_if_pc,          32'd0);
    check("t6_async_instr", o_if_instr,       NOP);
    check("t6_async_state", 32'(o_dbg_state), 32'd0);
    lat = 1;
    tick();
    exp_req_q = '{32'h0, 32'h4, 32'h8};
    exp_q     = '{32'h0, 32'h4, 32'h8};
    rst = 1'b0;
    tick();
    check("t6_stale_valid", 32'(o_if_valid), 32'd0);
    repeat (15) tick();
    finish_test("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
